// File: rtl/xcvr_avmm_arb_pkg.sv
// Shared definitions for the transceiver AVMM reconfiguration arbiter.
//   arb_state_e       : one-hot FSM state encoding
//   TIMEOUT_RDATA_BIT : fill value replicated across readdata on an aborted transaction
package xcvr_arb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_CMD    = 4'b0010,
        ST_RDWAIT = 4'b0100,
        ST_RESP   = 4'b1000
    } arb_state_e;

    localparam logic TIMEOUT_RDATA_BIT = 1'b1;

endpackage

// File: rtl/xcvr_avmm_arb_if.sv
// Bundle of requester-side and AVMM-side signals of the arbiter.
//   slave  : arbiter view (serves requesters, drives the AVMM command)
//   master : environment view (requesters plus AVMM endpoint)
interface xcvr_avmm_arb_if #(
    parameter int NUM_REQ     = 4,
    parameter int AVMM_ADDR_W = 13,
    parameter int DATA_W      = 32
);
    logic [NUM_REQ-1:0]             i_req_read;
    logic [NUM_REQ-1:0]             i_req_write;
    logic [NUM_REQ*AVMM_ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ*DATA_W-1:0]      i_req_writedata;
    logic [NUM_REQ-1:0]             o_req_ack;
    logic [DATA_W-1:0]              o_req_readdata;
    logic                           o_req_err;
    logic [NUM_REQ-1:0]             o_grant;
    logic [AVMM_ADDR_W-1:0]         o_avmm_addr;
    logic [DATA_W-1:0]              o_avmm_writedata;
    logic                           o_avmm_read;
    logic                           o_avmm_write;
    logic [DATA_W-1:0]              i_avmm_readdata;
    logic                           i_avmm_readdata_valid;
    logic                           i_avmm_waitrequest;

    modport slave (
        input  i_req_read, i_req_write, i_req_addr, i_req_writedata,
        input  i_avmm_readdata, i_avmm_readdata_valid, i_avmm_waitrequest,
        output o_req_ack, o_req_readdata, o_req_err, o_grant,
        output o_avmm_addr, o_avmm_writedata, o_avmm_read, o_avmm_write
    );

    modport master (
        output i_req_read, i_req_write, i_req_addr, i_req_writedata,
        output i_avmm_readdata, i_avmm_readdata_valid, i_avmm_waitrequest,
        input  o_req_ack, o_req_readdata, o_req_err, o_grant,
        input  o_avmm_addr, o_avmm_writedata, o_avmm_read, o_avmm_write
    );
endinterface

// File: rtl/xcvr_avmm_arb_rr_arb.sv
// Combinational round-robin winner selection.
//   req    : pending request vector
//   ptr    : index of the last granted requester
//   any    : at least one request pending
//   idx    : winning index (first pending after ptr, wrapping)
//   onehot : winner as a one-hot vector, zero when nothing pending
module xcvr_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);
    int k;

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        k      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[k]) begin
                any = 1'b1;
                idx = PTR_W'(k);
            end
        end
        onehot = any ? (NUM_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/xcvr_avmm_arb.sv
// Round-robin arbiter sharing one AVMM reconfiguration port among NUM_REQ requesters.
//   i_avmm_clk   : reconfig clock
//   i_avmm_rst_n : asynchronous active-low reset
//   bus          : requester handshakes, shared response, registered AVMM command
// A transaction that sees neither acceptance nor read data within TIMEOUT cycles of
// command/read-wait is aborted with err=1 and all-ones readdata.
module xcvr_avmm_arb
    import xcvr_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int AVMM_ADDR_W = 13,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 1023
) (
    input logic            i_avmm_clk,
    input logic            i_avmm_rst_n,
    xcvr_avmm_arb_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] IDLE   = ST_IDLE;
    localparam logic [3:0] CMD    = ST_CMD;
    localparam logic [3:0] RDWAIT = ST_RDWAIT;
    localparam logic [3:0] RESP   = ST_RESP;

    logic [3:0]             state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       win_idx;
    logic                   win_any;
    logic [NUM_REQ-1:0]     req_any;
    logic [NUM_REQ-1:0]     win_oh;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     ack;
    logic [TMR_W-1:0]       timer;
    logic                   cur_wr;
    logic                   cmd_rd;
    logic                   cmd_wr;
    logic                   err;
    logic [AVMM_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      wdata;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   accept;
    logic                   finish_ok;
    logic                   abort;

    // a requester with both read and write high is arbitrated as a write
    assign req_any = bus.i_req_read | bus.i_req_write;

    xcvr_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arb (
        .req    (req_any),
        .ptr    (rr_ptr),
        .any    (win_any),
        .idx    (win_idx),
        .onehot (win_oh)
    );

    assign busy      = (state == CMD) || (state == RDWAIT);
    assign accept    = (state == CMD) && !bus.i_avmm_waitrequest;
    assign finish_ok = (accept && (cur_wr || bus.i_avmm_readdata_valid)) ||
                       ((state == RDWAIT) && bus.i_avmm_readdata_valid);
    // real completion wins over the timeout in the same cycle; a read accepted on the
    // last allowed cycle without data is aborted instead of entering RDWAIT
    assign abort     = busy && !finish_ok && (timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge i_avmm_clk or negedge i_avmm_rst_n) begin
        if (!i_avmm_rst_n) begin
            state  <= IDLE;
            rr_ptr <= PTR_W'(NUM_REQ - 1);
            grant  <= '0;
            ack    <= '0;
            timer  <= '0;
            cur_wr <= 1'b0;
            cmd_rd <= 1'b0;
            cmd_wr <= 1'b0;
            err    <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            rdata  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant  <= win_oh;
                        rr_ptr <= win_idx;
                        addr   <= bus.i_req_addr[int'(win_idx)*AVMM_ADDR_W +: AVMM_ADDR_W];
                        wdata  <= bus.i_req_writedata[int'(win_idx)*DATA_W +: DATA_W];
                        cur_wr <= bus.i_req_write[win_idx];
                        cmd_wr <= bus.i_req_write[win_idx];
                        cmd_rd <= !bus.i_req_write[win_idx];
                        timer  <= '0;
                        state  <= CMD;
                    end
                end
                CMD, RDWAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (finish_ok || abort) begin
                        cmd_rd <= 1'b0;
                        cmd_wr <= 1'b0;
                        ack    <= grant;
                        err    <= abort;
                        if (abort) begin
                            rdata <= {DATA_W{TIMEOUT_RDATA_BIT}};
                        end else if (!cur_wr) begin
                            rdata <= bus.i_avmm_readdata;
                        end
                        state <= RESP;
                    end else if (accept) begin
                        cmd_rd <= 1'b0;
                        state  <= RDWAIT;
                    end
                end
                RESP: begin
                    grant <= '0;
                    state <= IDLE;
                end
                default: begin
                    grant  <= '0;
                    cmd_rd <= 1'b0;
                    cmd_wr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_req_ack        = ack;
    assign bus.o_req_readdata   = rdata;
    assign bus.o_req_err        = err;
    assign bus.o_grant          = grant;
    assign bus.o_avmm_addr      = addr;
    assign bus.o_avmm_writedata = wdata;
    assign bus.o_avmm_read      = cmd_rd;
    assign bus.o_avmm_write     = cmd_wr;
endmodule

// File: tb/tb_xcvr_avmm_arb.sv
module tb_xcvr_avmm_arb;
    localparam int NR  = 4;
    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xcvr_avmm_arb_if #(.NUM_REQ(NR), .AVMM_ADDR_W(AW), .DATA_W(DW)) bus ();

    xcvr_avmm_arb #(.NUM_REQ(NR), .AVMM_ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .i_avmm_clk   (clk),
        .i_avmm_rst_n (rst_n),
        .bus          (bus)
    );

    int errors = 0;
    int checks = 0;
    int last_g = NR - 1;          // reference model: last granted requester
    logic [DW-1:0] model_rd = '0; // reference model: response readdata register

    typedef struct {
        int            t_wait;
        int            ack_t;
        int            cmd_cyc;
        logic [NR-1:0] gnt;
        logic [NR-1:0] ack;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          err;
        logic [DW-1:0] rd;
        logic          cmd_at_ack;
        logic          unstable;
    } obs_t;

    typedef struct {
        int            idx;
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int            w;
        int            d;
        logic [DW-1:0] rdata;
        logic          drop;
        int            exp_t;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        int            exp_cmd;
    } row_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int k, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bus.i_req_read[k]               = rd;
        bus.i_req_write[k]              = wr;
        bus.i_req_addr[k*AW +: AW]      = a;
        bus.i_req_writedata[k*DW +: DW] = wd;
    endtask

    task automatic clear_inputs();
        bus.i_req_read            = '0;
        bus.i_req_write           = '0;
        bus.i_req_addr            = '0;
        bus.i_req_writedata       = '0;
        bus.i_avmm_readdata       = '0;
        bus.i_avmm_readdata_valid = 1'b0;
        bus.i_avmm_waitrequest    = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_grant"}, 64'(bus.o_grant), 64'(0));
        chk({tag, "_ack"},   64'(bus.o_req_ack), 64'(0));
        chk({tag, "_cmd"},   64'({bus.o_avmm_read, bus.o_avmm_write}), 64'(0));
        chk({tag, "_addr"},  64'(bus.o_avmm_addr), 64'(0));
        chk({tag, "_wdata"}, 64'(bus.o_avmm_writedata), 64'(0));
        chk({tag, "_rdata"}, 64'(bus.o_req_readdata), 64'(0));
        chk({tag, "_err"},   64'(bus.o_req_err), 64'(0));
    endtask

    // Called at a negedge with requests already driven. Plays the AVMM endpoint:
    // waitrequest high for the first w command cycles, readdata_valid d cycles after
    // acceptance (d=0: same cycle). t counts cycles from the first command cycle.
    task automatic run_txn(input int w, input int d, input logic [DW-1:0] rdata,
                           input logic drop_early, output obs_t o);
        int   t;
        logic done;
        o = '{default: 0};
        o.ack_t = -1;
        while (!(bus.o_avmm_read || bus.o_avmm_write) && o.t_wait < 40) begin
            @(negedge clk);
            o.t_wait++;
        end
        chk("cmd_start", 64'(bus.o_avmm_read || bus.o_avmm_write), 64'(1));
        if (!(bus.o_avmm_read || bus.o_avmm_write)) return;
        o.gnt  = bus.o_grant;
        o.addr = bus.o_avmm_addr;
        o.wd   = bus.o_avmm_writedata;
        o.wr   = bus.o_avmm_write;
        if (drop_early) begin
            bus.i_req_read  = '0;
            bus.i_req_write = '0;
        end
        t    = 0;
        done = 1'b0;
        while (!done && t < 40) begin
            if (bus.o_req_ack != '0) begin
                done         = 1'b1;
                o.ack_t      = t;
                o.ack        = bus.o_req_ack;
                o.err        = bus.o_req_err;
                o.rd         = bus.o_req_readdata;
                o.cmd_at_ack = bus.o_avmm_read || bus.o_avmm_write;
            end else begin
                if (bus.o_avmm_read || bus.o_avmm_write) begin
                    o.cmd_cyc++;
                    if (bus.o_avmm_addr !== o.addr || bus.o_avmm_writedata !== o.wd ||
                        bus.o_avmm_write !== o.wr)
                        o.unstable = 1'b1;
                end
                bus.i_avmm_waitrequest    = (t < w);
                bus.i_avmm_readdata_valid = !o.wr && (t == w + d);
                bus.i_avmm_readdata       = (t == w + d) ? rdata : DW'($urandom);
                @(negedge clk);
                t++;
            end
        end
        // stray readdata_valid during RESP must not disturb the held response
        bus.i_avmm_waitrequest    = 1'b0;
        bus.i_avmm_readdata_valid = 1'b1;
        bus.i_avmm_readdata       = ~rdata;
        bus.i_req_read            = bus.i_req_read & ~o.ack;
        bus.i_req_write           = bus.i_req_write & ~o.ack;
        @(negedge clk);
        bus.i_avmm_readdata_valid = 1'b0;
        chk("ack_one_cycle", 64'(bus.o_req_ack), 64'(0));
        chk("grant_cleared", 64'(bus.o_grant), 64'(0));
        chk("rd_held",       64'(bus.o_req_readdata), 64'(o.rd));
    endtask

    // Expected result from the timing rules: the transaction needs w (+d for reads)
    // cycles before completing; more than TMO-1 means it is aborted after TMO cycles.
    task automatic check_txn(input string tag, input obs_t o, input int exp_idx,
                             input logic exp_wr, input logic [AW-1:0] ea,
                             input logic [DW-1:0] ewd, input int w, input int d,
                             input logic [DW-1:0] rdata);
        int  need;
        logic ok;
        need = w + (exp_wr ? 0 : d);
        ok   = (need <= TMO - 1);
        if (!ok)         model_rd = '1;
        else if (!exp_wr) model_rd = rdata;
        chk({tag, "_grant"},   64'(o.gnt), 64'(1) << exp_idx);
        chk({tag, "_ack"},     64'(o.ack), 64'(1) << exp_idx);
        chk({tag, "_is_wr"},   64'(o.wr), 64'(exp_wr));
        chk({tag, "_addr"},    64'(o.addr), 64'(ea));
        if (exp_wr) chk({tag, "_wdata"}, 64'(o.wd), 64'(ewd));
        chk({tag, "_t_wait"},  64'(o.t_wait), 64'(1));
        chk({tag, "_ack_t"},   64'(o.ack_t), 64'(ok ? need + 1 : TMO));
        chk({tag, "_cmd_cyc"}, 64'(o.cmd_cyc), 64'((w + 1 < TMO) ? w + 1 : TMO));
        chk({tag, "_err"},     64'(o.err), 64'(!ok));
        chk({tag, "_rdata"},   64'(o.rd), 64'(model_rd));
        chk({tag, "_cmd_off"}, 64'(o.cmd_at_ack), 64'(0));
        chk({tag, "_stable"},  64'(o.unstable), 64'(0));
    endtask

    task automatic run_batch(input logic [NR-1:0] mask, input logic rand_timing);
        logic [AW-1:0] a  [NR];
        logic [DW-1:0] wd [NR];
        logic          wr [NR];
        logic [NR-1:0] pend;
        obs_t          o;
        int            win;
        int            w;
        int            d;
        logic [DW-1:0] rdata;
        for (int k = 0; k < NR; k++) begin
            a[k]  = AW'($urandom);
            wd[k] = DW'($urandom);
            wr[k] = 1'($urandom_range(0, 1));
            if (mask[k]) set_req(k, wr[k] ? 1'($urandom_range(0, 1)) : 1'b1, wr[k], a[k], wd[k]);
        end
        pend = mask;
        while (pend != '0) begin
            win = -1;
            for (int i = 1; i <= NR; i++) begin
                int k = (last_g + i) % NR;
                if (win < 0 && pend[k]) win = k;
            end
            w = 0;
            if (rand_timing)
                w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 4));
            d     = int'($urandom_range(0, 5));
            rdata = DW'($urandom);
            run_txn(w, d, rdata, 1'b0, o);
            check_txn($sformatf("rr%0d", win), o, win, wr[win], a[win], wd[win], w, d, rdata);
            pend[win] = 1'b0;
            last_g    = win;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        last_g   = NR - 1;
        model_rd = '0;
    endtask

    row_t tbl[11];
    obs_t obs;
    int   tw;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{0, 1'b0, 1'b1, 13'h010,  32'hA5A5_0001, 2,  0, 32'h0,          1'b0, 3,  1'b0, 32'h0000_0000, 3};
        tbl[1]  = '{2, 1'b1, 1'b0, 13'h020,  32'h0,         0,  4, 32'h1234_5678,  1'b0, 5,  1'b0, 32'h1234_5678, 1};
        tbl[2]  = '{1, 1'b1, 1'b0, 13'h0AB,  32'h0,         40, 0, 32'h7777_7777,  1'b0, 16, 1'b1, 32'hFFFF_FFFF, 16};
        tbl[3]  = '{3, 1'b1, 1'b1, 13'h1FFF, 32'hDEAD_BEEF, 0,  0, 32'h0,          1'b0, 1,  1'b0, 32'hFFFF_FFFF, 1};
        tbl[4]  = '{0, 1'b0, 1'b1, 13'h111,  32'h0000_0F0F, 15, 0, 32'h0,          1'b0, 16, 1'b0, 32'hFFFF_FFFF, 16};
        tbl[5]  = '{1, 1'b1, 1'b0, 13'h222,  32'h0,         15, 0, 32'h0BAD_F00D,  1'b0, 16, 1'b0, 32'h0BAD_F00D, 16};
        tbl[6]  = '{2, 1'b1, 1'b0, 13'h333,  32'h0,         15, 1, 32'h2468_ACE0,  1'b0, 16, 1'b1, 32'hFFFF_FFFF, 16};
        tbl[7]  = '{3, 1'b1, 1'b0, 13'h444,  32'h0,         3,  12, 32'h1357_9BDF, 1'b0, 16, 1'b0, 32'h1357_9BDF, 4};
        tbl[8]  = '{0, 1'b1, 1'b0, 13'h555,  32'h0,         3,  13, 32'h0000_1111, 1'b0, 16, 1'b1, 32'hFFFF_FFFF, 4};
        tbl[9]  = '{1, 1'b1, 1'b0, 13'h666,  32'h0,         1,  2, 32'h55AA_55AA,  1'b1, 4,  1'b0, 32'h55AA_55AA, 2};
        tbl[10] = '{2, 1'b0, 1'b1, 13'h777,  32'hCAFE_0002, 0,  0, 32'h0,          1'b0, 1,  1'b0, 32'h55AA_55AA, 1};

        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // directed single-requester transactions
        for (int r = 0; r < 11; r++) begin
            set_req(tbl[r].idx, tbl[r].rd, tbl[r].wr, tbl[r].a, tbl[r].wd);
            run_txn(tbl[r].w, tbl[r].d, tbl[r].rdata, tbl[r].drop, obs);
            chk($sformatf("row%0d_grant", r),   64'(obs.gnt), 64'(1) << tbl[r].idx);
            chk($sformatf("row%0d_ack", r),     64'(obs.ack), 64'(1) << tbl[r].idx);
            chk($sformatf("row%0d_is_wr", r),   64'(obs.wr), 64'(tbl[r].wr));
            chk($sformatf("row%0d_addr", r),    64'(obs.addr), 64'(tbl[r].a));
            chk($sformatf("row%0d_wdata", r),   64'(obs.wd), 64'(tbl[r].wd));
            chk($sformatf("row%0d_t_wait", r),  64'(obs.t_wait), 64'(1));
            chk($sformatf("row%0d_ack_t", r),   64'(obs.ack_t), 64'(tbl[r].exp_t));
            chk($sformatf("row%0d_cmd_cyc", r), 64'(obs.cmd_cyc), 64'(tbl[r].exp_cmd));
            chk($sformatf("row%0d_err", r),     64'(obs.err), 64'(tbl[r].exp_err));
            chk($sformatf("row%0d_rdata", r),   64'(obs.rd), 64'(tbl[r].exp_rd));
            chk($sformatf("row%0d_cmd_off", r), 64'(obs.cmd_at_ack), 64'(0));
        end

        // all four pending after reset, then requesters 0 and 1 again
        do_reset();
        run_batch(4'b1111, 1'b0);
        run_batch(4'b0011, 1'b0);

        // randomized request sets and endpoint timing against the reference model
        for (int n = 0; n < 40; n++) begin
            run_batch(NR'($urandom_range(1, (1 << NR) - 1)), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // reset while waiting for read data
        set_req(1, 1'b1, 1'b0, 13'h0C1, 32'h0);
        tw = 0;
        while (!bus.o_avmm_read && tw < 20) begin
            @(negedge clk);
            tw++;
        end
        chk("rst_mid_cmd", 64'(bus.o_avmm_read), 64'(1));
        bus.i_avmm_waitrequest = 1'b0;
        @(negedge clk);
        chk("rst_mid_rdwait", 64'({bus.o_avmm_read, bus.o_req_ack}), 64'(0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst_async");
        bus.i_avmm_readdata_valid = 1'b1;
        bus.i_avmm_readdata       = 32'h9999_9999;
        @(negedge clk);
        chk("rst_no_ack", 64'(bus.o_req_ack), 64'(0));
        @(negedge clk);
        chk("rst_no_ack2", 64'(bus.o_req_ack), 64'(0));
        clear_inputs();
        rst_n    = 1'b1;
        last_g   = NR - 1;
        model_rd = '0;
        run_batch(4'b0111, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
